clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter N_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 25, counter/divisor width in bits.
REQ-003 Parameter DEF_DIV, default 2500, reset period in clk cycles for every channel.
REQ-004 Parameter DEF_HIGH, default DEF_DIV/2, reset high-time in clk cycles for every channel.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 en  in  N_CH  per-channel count enable.
REQ-008 clr  in  N_CH  per-channel synchronous phase clear.
REQ-009 cfg_we  in  1  configuration write strobe, one cycle.
REQ-010 cfg_ch  in  $clog2(N_CH) (min 1)  target channel of write.
REQ-011 cfg_div  in  CNT_W  new period P in cycles.
REQ-012 cfg_high  in  CNT_W  new high-time H in cycles.
REQ-013 clk_out  out  N_CH  registered divided clocks.
REQ-014 tick  out  N_CH  registered one-cycle pulse at the last cycle of each period.
REQ-015 cfg_pend  out  N_CH  shadow config written but not yet active.

Function
REQ-016 Each channel SHALL hold active P_act/H_act, shadow P_sh/H_sh, counter cnt (CNT_W bits), and the cfg_pend flag.
REQ-017 Effective period SHALL be max(P_act,2); cfg_div values 0 and 1 SHALL behave as 2.
REQ-018 With en=1, cnt SHALL increment each cycle and wrap from Peff-1 to 0; with en=0, cnt, clk_out, and the active config SHALL hold and tick SHALL be 0.
REQ-019 clk_out SHALL register (cnt < H_act) each enabled cycle, one-cycle latency: high H cycles, low Peff-H cycles per period; H=0 gives constant low; H>=Peff gives constant high.
REQ-020 tick SHALL be 1 for exactly the cycle after an enabled cycle in which cnt==Peff-1.
REQ-021 cfg_we SHALL write cfg_div/cfg_high into the cfg_ch shadow and set cfg_pend; cfg_ch>=N_CH SHALL be ignored.
REQ-022 A pending shadow SHALL become active at the wrap (cnt Peff-1 -> 0), so no truncated or stretched period occurs; cfg_pend SHALL clear in the same edge.
REQ-023 If the channel has en=0 or clr=1, a pending shadow SHALL become active at the next edge.
REQ-024 A second cfg_we to a pending channel SHALL overwrite the shadow; the last write wins.
REQ-025 cfg_we coinciding with the wrap edge SHALL be captured as pending and applied at the following wrap; the old shadow is applied at this wrap.
REQ-026 clr=1 SHALL set cnt=0, clk_out=0, and tick=0 at the next edge, regardless of en; clr SHALL override en.
REQ-027 Channels SHALL be fully independent; a simultaneous wrap on all channels SHALL be legal.

Reset
REQ-028 On rst=1, every channel SHALL immediately set cnt=0, clk_out=0, tick=0, cfg_pend=0, P_act=P_sh=DEF_DIV, and H_act=H_sh=DEF_HIGH.
REQ-029 rst asserted mid-period SHALL discard pending configuration; counting SHALL restart from 0 on the first enabled edge after release.

Structure
REQ-030 A shared package SHALL hold the CNT_W default, the DEF_DIV/DEF_HIGH defaults, and the channel-config struct type {period, high}.
REQ-031 One sub-module, clk_div_chan, SHALL implement a single channel (counter, shadow, compare); clk_div_bank SHALL generate N_CH instances and decode cfg_ch.

Verification
REQ-032 Test 1 (N_CH=2, CNT_W=8, DEF_DIV=4, DEF_HIGH=2), reset release, en=11: clk_out SHALL show the pattern 1100 repeating on both channels, and tick SHALL pulse every 4th cycle.
REQ-033 Test 2, mid-period write ch0 P=6 H=1: cfg_pend[0]=1 until the wrap, the current period SHALL complete as 4 cycles, the next period SHALL be 100000, and cfg_pend[0] SHALL then drop.
REQ-034 Test 3, write P=0 H=5 then P=1 H=0: the first SHALL give constant-high period-2 ticks; the second SHALL give constant-low ticks every 2 cycles.
REQ-035 Test 4, en[1]=0 for 3 cycles mid-period: ch1 SHALL freeze cnt and clk_out, tick[1]=0; a write during the freeze SHALL be active on the next edge.
REQ-036 Test 5, clr[0] pulsed together with en[0]=1, plus two back-to-back writes (P=8, then P=5): cnt SHALL restart at 0 and clk_out[0]=0; only P=5 SHALL be applied.
REQ-037 Test 6, rst asserted asynchronously mid-period with a pending write: all outputs SHALL be 0 before the next clk edge, the pending write SHALL be lost, and the period SHALL return to 4.

Source files
------------

// File: rtl/clk_div_bank_pkg.sv
// Shared types and reset defaults for the
// clock divider bank and its channels.
package clk_div_bank_pkg;

  localparam int CNT_W_DEF    = 25;
  localparam int DEF_DIV_DEF  = 2500;
  localparam int DEF_HIGH_DEF = DEF_DIV_DEF / 2;
  localparam int CFG_W        = 32;

  typedef struct packed {
    logic [CFG_W-1:0] period;
    logic [CFG_W-1:0] high;
  } chan_cfg_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow config
// and high-time compare.
module clk_div_chan
  import clk_div_bank_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_DIV  = DEF_DIV_DEF,
  parameter int DEF_HIGH = DEF_DIV / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             we,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  localparam chan_cfg_t RST_CFG = '{
    period: CFG_W'(DEF_DIV),
    high:   CFG_W'(DEF_HIGH)
  };

  chan_cfg_t        act_q, act_d;
  chan_cfg_t        sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [CFG_W-1:0] peff;
  logic [CFG_W-1:0] cnt_x;
  logic             at_end;
  logic             apply;

  always_comb begin
    peff = (act_q.period < CFG_W'(2)) ? CFG_W'(2)
                                      : act_q.period;
    cnt_x = CFG_W'(cnt_q);
    // >= so a shorter period loaded while frozen still wraps
    at_end = en && (cnt_x >= peff - CFG_W'(1));
    apply  = pend_q && (clr || !en || at_end);

    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    act_d  = act_q;
    sh_d   = sh_q;
    pend_d = pend_q;

    if (clr) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (en) begin
      clk_d  = cnt_x < act_q.high;
      tick_d = at_end;
      cnt_d  = at_end ? '0 : cnt_q + CNT_W'(1);
    end

    if (apply) begin
      act_d  = sh_q;
      pend_d = 1'b0;
    end

    if (we) begin
      sh_d = '{
        period: CFG_W'(cfg_div),
        high:   CFG_W'(cfg_high)
      };
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      pend_q <= 1'b0;
      act_q  <= RST_CFG;
      sh_q   <= RST_CFG;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      sh_q   <= sh_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pend    = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH independent programmable clock
// dividers sharing one config write port.
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_DIV  = DEF_DIV_DEF,
  parameter int DEF_HIGH = DEF_DIV / 2,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic [N_CH-1:0]  clr,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  cfg_pend
);

  logic [N_CH-1:0] we_ch;

  // cfg_ch values with no matching channel select nothing
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign we_ch[i] = cfg_we && (cfg_ch == CH_W'(i));

    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV),
      .DEF_HIGH(DEF_HIGH)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .clr     (clr[i]),
      .we      (we_ch[i]),
      .cfg_div (cfg_div),
      .cfg_high(cfg_high),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pend    (cfg_pend[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: directed scenarios plus
// random traffic against a per-period waveform model.
module tb_clk_div_bank;

  localparam int NC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] en = '0;
  logic [1:0] clr = '0;
  logic       cfg_we = 1'b0;
  logic [0:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic [7:0] cfg_high = '0;
  logic [1:0] clk_out;
  logic [1:0] tick;
  logic [1:0] cfg_pend;

  int n_chk = 0;
  int n_fail = 0;

  clk_div_bank #(
    .N_CH(2), .CNT_W(8), .DEF_DIV(4), .DEF_HIGH(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high),
    .clk_out(clk_out), .tick(tick), .cfg_pend(cfg_pend)
  );

  always #5 clk = ~clk;

  // Model: each period is a list of (high, last) samples;
  // every enabled cycle consumes one sample.
  typedef struct {bit hi; bit last;} smp_t;
  smp_t mq[NC][$];
  int   m_per[NC], m_hi[NC], m_sper[NC], m_shi[NC], m_pos[NC];
  bit   m_pend[NC], m_clk[NC], m_tick[NC];

  function automatic void refill(int c);
    int pe;
    pe = (m_per[c] < 2) ? 2 : m_per[c];
    mq[c].delete();
    if (m_pos[c] >= pe)
      mq[c].push_back('{m_pos[c] < m_hi[c], 1'b1});
    else
      for (int k = m_pos[c]; k < pe; k++)
        mq[c].push_back('{k < m_hi[c], k == pe - 1});
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_per[c] = 4; m_hi[c] = 2; m_sper[c] = 4; m_shi[c] = 2;
      m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0; m_pos[c] = 0;
      refill(c);
    end
  endfunction

  function automatic void model_edge();
    for (int c = 0; c < NC; c++) begin
      bit rolls, take;
      smp_t s;
      rolls = en[c] && !clr[c] && mq[c].size() == 1;
      take = m_pend[c] && (clr[c] || !en[c] || rolls);
      if (clr[c]) begin
        m_clk[c] = 0; m_tick[c] = 0; m_pos[c] = 0;
      end else if (en[c]) begin
        s = mq[c].pop_front();
        m_clk[c] = s.hi; m_tick[c] = s.last; m_pos[c]++;
      end else begin
        m_tick[c] = 0;
      end
      if (take) begin
        m_per[c] = m_sper[c]; m_hi[c] = m_shi[c]; m_pend[c] = 0;
      end
      if (cfg_we && int'(cfg_ch) == c) begin
        m_sper[c] = int'(cfg_div); m_shi[c] = int'(cfg_high);
        m_pend[c] = 1;
      end
      if (clr[c] || rolls) m_pos[c] = 0;
      if (clr[c] || rolls || take) refill(c);
    end
  endfunction

  function automatic logic [5:0] mexp();
    return {m_pend[1], m_pend[0], m_tick[1], m_tick[0],
            m_clk[1], m_clk[0]};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = '0;
    step(); step();
    n_chk++;
    if ({cfg_pend, tick, clk_out} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want 000000",
               {cfg_pend, tick, clk_out});
    end
    rst = 1'b0; en = 2'b11;
  endtask

  task automatic test_default_pattern();
    logic [7:0] pc, pt;
    pc = 8'b11001100; pt = 8'b00010001;
    for (int i = 0; i < 8; i++) begin
      step();
      n_chk++;
      if (clk_out !== {2{pc[7-i]}} || tick !== {2{pt[7-i]}}) begin
        n_fail++;
        $display("FAIL default_pattern cyc %0d got clk %b tick %b want %b %b",
                 i, clk_out, tick, {2{pc[7-i]}}, {2{pt[7-i]}});
      end
      n_chk++;
      if ({cfg_pend, tick, clk_out} !== mexp()) begin
        n_fail++;
        $display("FAIL model_default @%0t got %b want %b",
                 $time, {cfg_pend, tick, clk_out}, mexp());
      end
    end
  endtask

  task automatic test_mid_write();
    int n;
    logic [5:0] v;
    step();
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd6; cfg_high = 8'd1;
    step();
    cfg_we = 1'b0;
    n_chk++;
    if (cfg_pend[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midwr_pend_set got %b want 1", cfg_pend[0]);
    end
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_chk++;
      if ({cfg_pend, tick, clk_out} !== mexp()) begin
        n_fail++;
        $display("FAIL model_midwr @%0t got %b want %b",
                 $time, {cfg_pend, tick, clk_out}, mexp());
      end
      if (tick[0]) begin n = i; break; end
    end
    n_chk++;
    if (n != 2 || cfg_pend[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midwr_old_period got wrap after %0d pend %b want 2 0",
               n, cfg_pend[0]);
    end
    v = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      v = {v[4:0], clk_out[0]};
    end
    n_chk++;
    if (v !== 6'b100000 || tick[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midwr_new_period got %b tick %b want 100000 1",
               v, tick[0]);
    end
  endtask

  task automatic degen_case(input logic [7:0] p, input logic [7:0] h,
                            input int want_ones);
    int ones, ticks;
    bit ok;
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_div = p; cfg_high = h;
    step();
    cfg_we = 1'b0;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++;
      if ({cfg_pend, tick, clk_out} !== mexp()) begin
        n_fail++;
        $display("FAIL model_degen @%0t got %b want %b",
                 $time, {cfg_pend, tick, clk_out}, mexp());
      end
      if (!cfg_pend[0]) begin ok = 1; break; end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL degen_apply_timeout got pend 1 want 0");
    end
    ones = 0; ticks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      ones += int'(clk_out[0]);
      ticks += int'(tick[0]);
    end
    n_chk++;
    if (ones != want_ones || ticks != 3) begin
      n_fail++;
      $display("FAIL degen_p%0d_h%0d got ones %0d ticks %0d want %0d 3",
               p, h, ones, ticks, want_ones);
    end
  endtask

  task automatic test_degenerate();
    degen_case(8'd0, 8'd5, 6);
    degen_case(8'd1, 8'd0, 0);
  endtask

  task automatic test_freeze();
    logic c1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick[1]) break;
    end
    step();
    en = 2'b01;
    c1 = clk_out[1];
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        cfg_we = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd6; cfg_high = 8'd3;
      end
      step();
      cfg_we = 1'b0;
      n_chk++;
      if (clk_out[1] !== c1 || tick[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze_hold cyc %0d got clk %b tick %b want %b 0",
                 i, clk_out[1], tick[1], c1);
      end
      if (i >= 1) begin
        n_chk++;
        if (cfg_pend[1] !== (i == 1)) begin
          n_fail++;
          $display("FAIL freeze_apply cyc %0d got pend %b want %b",
                   i, cfg_pend[1], i == 1);
        end
      end
    end
    en = 2'b11;
    for (int i = 0; i < 8; i++) begin
      step();
      n_chk++;
      if ({cfg_pend, tick, clk_out} !== mexp()) begin
        n_fail++;
        $display("FAIL model_freeze @%0t got %b want %b",
                 $time, {cfg_pend, tick, clk_out}, mexp());
      end
    end
  endtask

  task automatic test_clr_back_to_back();
    logic [4:0] v;
    clr = 2'b01;
    step();
    clr = 2'b00;
    n_chk++;
    if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_first got clk %b tick %b want 0 0",
               clk_out[0], tick[0]);
    end
    step();
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd8; cfg_high = 8'd4;
    step();
    cfg_div = 8'd5; cfg_high = 8'd2;
    step();
    cfg_we = 1'b0;
    n_chk++;
    if (cfg_pend[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_pend got %b want 1", cfg_pend[0]);
    end
    step();
    n_chk++;
    if (cfg_pend[0] !== 1'b0 || tick[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_apply got pend %b tick %b want 0 1",
               cfg_pend[0], tick[0]);
    end
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        step(); step();
        clr = 2'b01;
        step();
        clr = 2'b00;
        n_chk++;
        if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL clr_mid got clk %b tick %b want 0 0",
                   clk_out[0], tick[0]);
        end
      end
      v = '0;
      for (int i = 0; i < 5; i++) begin
        step();
        v = {v[3:0], clk_out[0]};
        n_chk++;
        if ({cfg_pend, tick, clk_out} !== mexp()) begin
          n_fail++;
          $display("FAIL model_b2b @%0t got %b want %b",
                   $time, {cfg_pend, tick, clk_out}, mexp());
        end
      end
      n_chk++;
      if (v !== 5'b11000 || tick[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_period5 pass %0d got %b tick %b want 11000 1",
                 r, v, tick[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] pc, pt;
    pc = 8'b11001100; pt = 8'b00010001;
    cfg_we = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd9; cfg_high = 8'd1;
    step();
    cfg_we = 1'b0;
    n_chk++;
    if (cfg_pend[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pend_before got %b want 1", cfg_pend[1]);
    end
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    n_chk++;
    if ({cfg_pend, tick, clk_out} !== 6'd0) begin
      n_fail++;
      $display("FAIL arst_immediate got %b want 000000",
               {cfg_pend, tick, clk_out});
    end
    step();
    rst = 1'b0; en = 2'b11;
    for (int i = 0; i < 8; i++) begin
      step();
      n_chk++;
      if (clk_out !== {2{pc[7-i]}} || tick !== {2{pt[7-i]}} ||
          cfg_pend !== 2'b00) begin
        n_fail++;
        $display("FAIL arst_period4 cyc %0d got clk %b tick %b pend %b",
                 i, clk_out, tick, cfg_pend);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      clr[0] = ($urandom_range(0, 15) == 0);
      clr[1] = ($urandom_range(0, 15) == 0);
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_ch = 1'($urandom_range(0, 1));
      cfg_div = 8'($urandom_range(0, 9));
      cfg_high = 8'($urandom_range(0, 10));
      step();
      n_chk++;
      if ({cfg_pend, tick, clk_out} !== mexp()) begin
        n_fail++;
        $display("FAIL model_random cyc %0d got %b want %b",
                 i, {cfg_pend, tick, clk_out}, mexp());
      end
    end
    en = 2'b11; clr = '0; cfg_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_default_pattern();
    test_mid_write();
    test_degenerate();
    test_freeze();
    test_clr_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
